// File: rtl/cell_bank_ctrl.sv
// Ping-pong bank controller between a frame writer and cell_fetch.
// Tracks per-bank fill state and sequences one fetch pass per full bank.
module cell_bank_ctrl #(
    parameter int CELL_NUM = 1200,
    parameter int FCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              wr_frame_done_i,
    output logic              wr_bank_o,
    output logic              wr_bank_ready_o,
    output logic              fetch_start_o,
    output logic              rd_bank_o,
    input  logic              cell_valid_i,
    input  logic              cell_ready_i,
    output logic              busy_o,
    output logic [FCNT_W-1:0] frame_cnt_o,
    output logic              overflow_o
);

    localparam int CNT_W = (CELL_NUM > 1) ? $clog2(CELL_NUM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         full_q, full_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic               overflow_q, overflow_d;

    logic hs;
    logic wr_accept;
    logic wr_reject;
    logic release_fr;

    always_comb begin
        hs         = cell_valid_i & cell_ready_i;
        // Write acceptance uses the pre-release fill state on purpose.
        wr_accept  = wr_frame_done_i & ~full_q[wr_bank_q];
        wr_reject  = wr_frame_done_i &  full_q[wr_bank_q];
        release_fr = (state_q == BUSY) & hs & (cnt_q == CNT_LAST);

        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_bank_d   = rd_bank_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (enable_i && full_q[rd_bank_q]) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (hs) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        rd_bank_d   = ~rd_bank_q;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        full_d = full_q;
        if (release_fr) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_accept) begin
            full_d[wr_bank_q] = 1'b1;
        end

        wr_bank_d  = wr_accept ? ~wr_bank_q : wr_bank_q;
        overflow_d = overflow_q | wr_reject;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign wr_bank_o       = wr_bank_q;
    assign wr_bank_ready_o = ~full_q[wr_bank_q];
    assign fetch_start_o   = (state_q == START);
    assign rd_bank_o       = rd_bank_q;
    assign busy_o          = (state_q != IDLE);
    assign frame_cnt_o     = frame_cnt_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_cell_bank_ctrl.sv
// Scoreboard bench for cell_bank_ctrl: stimulus pushes expected
// fetch starts / frame completions, a negedge monitor pops and compares.
module tb_cell_bank_ctrl;

    localparam int CN = 1200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0;
    logic        wr_frame_done_i = 1'b0;
    logic        cell_valid_i = 1'b0;
    logic        cell_ready_i = 1'b0;
    logic        wr_bank_o;
    logic        wr_bank_ready_o;
    logic        fetch_start_o;
    logic        rd_bank_o;
    logic        busy_o;
    logic [15:0] frame_cnt_o;
    logic        overflow_o;

    cell_bank_ctrl #(.CELL_NUM(CN), .FCNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable_i),
        .wr_frame_done_i (wr_frame_done_i),
        .wr_bank_o       (wr_bank_o),
        .wr_bank_ready_o (wr_bank_ready_o),
        .fetch_start_o   (fetch_start_o),
        .rd_bank_o       (rd_bank_o),
        .cell_valid_i    (cell_valid_i),
        .cell_ready_i    (cell_ready_i),
        .busy_o          (busy_o),
        .frame_cnt_o     (frame_cnt_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   c;
        logic b;
    } st_t;

    st_t start_q[$];
    int  done_q[$];
    int  passed = 0;
    int  total = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        st_t e;
        int  f;
        if (rst_n && fetch_start_o) begin
            if (start_q.size() == 0) begin
                chk("unexpected_start", 1, 0);
            end else begin
                e = start_q.pop_front();
                if (e.c >= 0) chk("start_cycle", cyc, e.c);
                chk("start_bank", rd_bank_o, e.b);
                chk("start_busy", busy_o, 1);
            end
        end
        if (rst_n && prev_busy && !busy_o) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                f = done_q.pop_front();
                chk("frame_cnt", frame_cnt_o, f);
            end
        end
        prev_busy = rst_n ? busy_o : 1'b0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_start", fetch_start_o, 0);
        chk("rst_wr_rdy", wr_bank_ready_o, 1);
        chk("rst_wr_bank", wr_bank_o, 0);
        chk("rst_rd_bank", rd_bank_o, 0);
        chk("rst_fcnt", frame_cnt_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("sb_start_empty", start_q.size(), 0);
        chk("sb_done_empty", done_q.size(), 0);
        start_q.delete();
        done_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic pulse_done(output int d);
        d = cyc;
        wr_frame_done_i = 1'b1;
        step();
        wr_frame_done_i = 1'b0;
    endtask

    task automatic wait_start();
        bit ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = fetch_start_o;
        end
        if (!ok) chk("start_timeout", 0, 1);
        step();
    endtask

    task automatic do_hs(input int n, input bit rnd, input bit done_last,
                         output int last);
        int i = 0;
        last = -1;
        cell_valid_i = 1'b1;
        while (i < n) begin
            cell_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_frame_done_i = done_last && cell_ready_i && (i == n - 1);
            if (cell_ready_i) begin
                i++;
                last = cyc;
            end
            step();
            wr_frame_done_i = 1'b0;
        end
        cell_valid_i = 1'b0;
        cell_ready_i = 1'b0;
    endtask

    int d, l;

    initial begin
        repeat (2) step();
        do_reset();

        // single frame, done at cycle 10
        enable_i = 1'b1;
        while (cyc < 10) step();
        pulse_done(d);
        start_q.push_back('{d + 2, 1'b0});
        wait_start();
        do_hs(CN, 1'b0, 1'b0, l);
        done_q.push_back(1);
        step();
        chk("sf_busy", busy_o, 0);
        chk("sf_fcnt", frame_cnt_o, 1);
        chk("sf_wr_rdy", wr_bank_ready_o, 1);
        chk("sf_wr_bank", wr_bank_o, 1);

        // ping-pong with back-to-back start
        do_reset();
        enable_i = 1'b1;
        pulse_done(d);
        start_q.push_back('{d + 2, 1'b0});
        wait_start();
        do_hs(100, 1'b0, 1'b0, l);
        pulse_done(d);
        chk("pp_wr_rdy", wr_bank_ready_o, 0);
        chk("pp_wr_bank", wr_bank_o, 0);
        do_hs(CN - 100, 1'b0, 1'b0, l);
        done_q.push_back(1);
        start_q.push_back('{l + 2, 1'b1});
        wait_start();
        do_hs(CN, 1'b0, 1'b0, l);
        done_q.push_back(2);
        step();
        chk("pp_fcnt", frame_cnt_o, 2);
        chk("pp_ovf", overflow_o, 0);

        // overflow on third pulse
        do_reset();
        enable_i = 1'b1;
        pulse_done(d);
        start_q.push_back('{d + 2, 1'b0});
        wait_start();
        pulse_done(d);
        pulse_done(d);
        chk("ov_flag", overflow_o, 1);
        chk("ov_wr_rdy", wr_bank_ready_o, 0);
        chk("ov_wr_bank", wr_bank_o, 0);
        chk("ov_fcnt", frame_cnt_o, 0);
        repeat (5) step();
        chk("ov_sticky", overflow_o, 1);
        chk("ov_busy", busy_o, 1);

        // backpressure and enable gating
        do_reset();
        enable_i = 1'b1;
        pulse_done(d);
        start_q.push_back('{d + 2, 1'b0});
        wait_start();
        enable_i = 1'b0;
        pulse_done(d);
        do_hs(CN, 1'b1, 1'b0, l);
        done_q.push_back(1);
        repeat (20) step();
        chk("bp_idle", busy_o, 0);
        chk("bp_wr_rdy", wr_bank_ready_o, 1);
        chk("bp_rd_bank", rd_bank_o, 1);
        enable_i = 1'b1;
        start_q.push_back('{cyc + 1, 1'b1});
        wait_start();
        do_hs(CN, 1'b1, 1'b0, l);
        done_q.push_back(2);
        step();
        chk("bp_fcnt", frame_cnt_o, 2);

        // release coincides with done for the releasing bank
        do_reset();
        enable_i = 1'b0;
        pulse_done(d);
        pulse_done(d);
        chk("sr_wr_rdy_full", wr_bank_ready_o, 0);
        enable_i = 1'b1;
        start_q.push_back('{cyc + 1, 1'b0});
        wait_start();
        do_hs(CN, 1'b0, 1'b1, l);
        done_q.push_back(1);
        start_q.push_back('{l + 2, 1'b1});
        chk("sr_ovf", overflow_o, 1);
        chk("sr_wr_bank", wr_bank_o, 0);
        chk("sr_wr_rdy", wr_bank_ready_o, 1);
        wait_start();
        do_hs(CN, 1'b0, 1'b0, l);
        done_q.push_back(2);
        step();

        // release coincides with done for the free bank
        do_reset();
        enable_i = 1'b1;
        pulse_done(d);
        start_q.push_back('{d + 2, 1'b0});
        wait_start();
        do_hs(CN, 1'b0, 1'b1, l);
        done_q.push_back(1);
        start_q.push_back('{l + 2, 1'b1});
        chk("sa_ovf", overflow_o, 0);
        chk("sa_wr_bank", wr_bank_o, 0);
        chk("sa_wr_rdy", wr_bank_ready_o, 1);
        wait_start();
        do_hs(CN, 1'b0, 1'b0, l);
        done_q.push_back(2);
        step();

        // reset mid-frame after 600 handshakes
        do_reset();
        enable_i = 1'b1;
        pulse_done(d);
        start_q.push_back('{d + 2, 1'b0});
        wait_start();
        do_hs(600, 1'b0, 1'b0, l);
        chk("mf_busy_pre", busy_o, 1);
        do_reset();
        repeat (30) step();
        chk("mf_busy", busy_o, 0);
        chk("mf_fcnt", frame_cnt_o, 0);
        chk("mf_wr_rdy", wr_bank_ready_o, 1);

        chk("end_start_q", start_q.size(), 0);
        chk("end_done_q", done_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
